// File: rtl/logic_unit_pipe_if.sv
// Handshake bundle for logic_unit_pipe: operand/op transfer in, flagged result out.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_ones;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_zero, out_ones
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out_data,
    output out_zero, out_ones
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with 2-entry skid result buffer.
// Optional LOGIC_UNIT_STATS_EN adds a saturating accepted-op counter.
module logic_unit_pipe #(
  parameter int WIDTH = 16
`ifdef LOGIC_UNIT_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  logic_unit_pipe_if.slave     bus
`ifdef LOGIC_UNIT_STATS_EN
  ,
  output logic [CNT_W-1:0]     op_count
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             ones;
  } entry_t;

  logic [1:0]       cnt;
  entry_t           head;
  entry_t           skid;
  entry_t           nxt;
  logic [WIDTH-1:0] res;
  logic             acc;
  logic             pop;

  always_comb begin
    res = '0;
    unique case (bus.op)
      3'b000: res = ~bus.a;
      3'b001: res = bus.a & bus.b;
      3'b010: res = bus.a | bus.b;
      3'b011: res = bus.a ^ bus.b;
      3'b100: res = ~(bus.a & bus.b);
      3'b101: res = ~(bus.a | bus.b);
      3'b110: res = ~(bus.a ^ bus.b);
      3'b111: res = bus.a;
    endcase
  end

  // Flags travel with the entry so the head never needs re-evaluation.
  always_comb begin
    nxt      = '0;
    nxt.data = res;
    nxt.zero = ~|res;
    nxt.ones = &res;
  end

  assign bus.in_ready  = (cnt != 2'd2);
  assign bus.out_valid = (cnt != 2'd0);
  assign bus.out_data  = head.data;
  assign bus.out_zero  = head.zero;
  assign bus.out_ones  = head.ones;

  assign acc = bus.in_valid & bus.in_ready;
  assign pop = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 2'd0;
      head <= '0;
      skid <= '0;
    end else if (clr) begin
      cnt <= 2'd0;
    end else begin
      unique case ({acc, pop})
        2'b10: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd0) head <= nxt;
          else             skid <= nxt;
        end
        2'b01: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd2) head <= skid;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            head <= nxt;
          end else begin
            head <= skid;
            skid <= nxt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LOGIC_UNIT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (clr) begin
      op_count <= '0;
    end else if (acc && (op_count != {CNT_W{1'b1}})) begin
      op_count <= op_count + 1'b1;
    end
  end
`else
  // No statistics counter in this build.
`endif

endmodule
